// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the byte-serial data-memory arbiter.
// Optional feature macro used by dmem_arbiter: DMEM_RR_ARB_EN (round-robin arbitration).
package dmem_arb_pkg;

  localparam int MEM_SIZE_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Number of bytes moved for a width code; 0 marks an unsupported code.
  function automatic logic [2:0] f3_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      F3_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-data extension: turns an assembled little-endian word into the
// architectural load result for the given width code.
module dmem_load_ext
  import dmem_arb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{word_i[7]}}, word_i[7:0]};
      F3_H:    data_o = {{16{word_i[15]}}, word_i[15:0]};
      F3_W:    data_o = word_i;
      F3_BU:   data_o = {24'd0, word_i[7:0]};
      F3_HU:   data_o = {16'd0, word_i[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter onto a byte-wide memory, serialising word and
// half-word accesses. Define DMEM_RR_ARB_EN for round-robin instead of CPU priority.
//
//   state | meaning
//   IDLE  | waiting for a request; latches the winner's command on accept
//   XFER  | one memory byte strobe per cycle
//   CAPT  | captures the last load byte returned by the memory
//   DONE  | one-cycle done/err/rdata to the granted port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_funct3,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_done,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              gnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [2:0]        n_q;
  logic [1:0]        cnt_q;
  logic [31:0]       word_q;

  logic        accept;
  logic        sel_dma;
  logic        sel_we;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_n;
  logic [32:0] sel_end;
  logic        sel_ok;
  logic        last_byte;
  logic        cap_en;
  logic [1:0]  cap_lane;
  logic [31:0] ld_data;

`ifdef DMEM_RR_ARB_EN
  logic last_q;
  assign sel_dma = d_req & (~c_req | ~last_q);
`else
  assign sel_dma = d_req & ~c_req;
`endif

  assign sel_we    = sel_dma ? d_we     : c_we;
  assign sel_f3    = sel_dma ? d_funct3 : c_funct3;
  assign sel_addr  = sel_dma ? d_addr   : c_addr;
  assign sel_wdata = sel_dma ? d_wdata  : c_wdata;
  assign sel_n     = f3_bytes(sel_f3);

  // 33-bit end address so accesses near 2^32 cannot wrap into range.
  assign sel_end = {1'b0, sel_addr} + {30'd0, sel_n} - 33'd1;
  assign sel_ok  = f3_legal(sel_f3, sel_we) && (sel_end < 33'(MEM_SIZE));

  assign accept    = (state_q == IDLE) && (c_req || d_req);
  assign last_byte = ({1'b0, cnt_q} == (n_q - 3'd1));

  // Memory read data lags the strobe by one cycle, so lane k lands one cycle later.
  assign cap_en   = ~we_q && (((state_q == XFER) && (cnt_q != 2'd0)) || (state_q == CAPT));
  assign cap_lane = (state_q == CAPT) ? (n_q[1:0] - 2'd1) : (cnt_q - 2'd1);

  dmem_load_ext u_load_ext (
    .word_i   (word_q),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c_done    = 1'b0;
    c_err     = 1'b0;
    c_rdata   = '0;
    d_done    = 1'b0;
    d_err     = 1'b0;
    d_rdata   = '0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_d = sel_ok ? XFER : DONE;
      end
      XFER: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q + ADDR_W'(cnt_q);
        mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
        if (last_byte) state_d = CAPT;
      end
      CAPT: state_d = DONE;
      DONE: begin
        state_d = IDLE;
        if (gnt_q) begin
          d_done  = 1'b1;
          d_err   = err_q;
          d_rdata = (err_q || we_q) ? 32'd0 : ld_data;
        end else begin
          c_done  = 1'b1;
          c_err   = err_q;
          c_rdata = (err_q || we_q) ? 32'd0 : ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      n_q     <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef DMEM_RR_ARB_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q   <= sel_dma;
        we_q    <= sel_we;
        f3_q    <= sel_f3;
        addr_q  <= sel_addr[ADDR_W-1:0];
        wdata_q <= sel_wdata;
        err_q   <= ~sel_ok;
        n_q     <= sel_n;
        cnt_q   <= '0;
        word_q  <= '0;
`ifdef DMEM_RR_ARB_EN
        last_q  <= sel_dma;
`endif
      end
      if (state_q == XFER) cnt_q <= cnt_q + 2'd1;
      if (cap_en) word_q[{cap_lane, 3'b000} +: 8] <= mem_rdata;
    end
  end

endmodule
